// File: rtl/arb_pkg.sv
// Shared encodings for the two-master Wishbone arbiter: FSM states, master
// indices and the watchdog counter sizing helper.
package arb_pkg;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } arb_state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DBG = 1'b1;

    // Watchdog counter must hold TIMEOUT itself; a disabled watchdog still needs 1 bit.
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/wb_req_latch.sv
// Per-master request holding register: captures a single strobe and keeps it
// pending until the arbiter completes or aborts it.
module wb_req_latch #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int SEL_W  = 4
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_stb,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_data,
    input  logic [SEL_W-1:0]  i_sel,
    input  logic              i_ack,
    input  logic              i_clear,
    output logic              o_pending,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_data,
    output logic [SEL_W-1:0]  o_sel
);

    logic accept;

    // A master still holding stb while it sees its ack must not be re-accepted.
    assign accept = i_stb && !o_pending && !i_ack;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_pending <= 1'b0;
        end else if (i_clear) begin
            o_pending <= 1'b0;
        end else if (accept) begin
            o_pending <= 1'b1;
        end
    end

    // NOTE: the payload is a plain data register qualified by o_pending, so it
    // needs no reset; leaving it out keeps the reset tree to control state only.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            o_we   <= i_we;
            o_addr <= i_addr;
            o_data <= i_data;
            o_sel  <= i_sel;
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master, one-slave Wishbone arbiter with per-master request latches,
// round-robin selection and a slave-ack watchdog.
module wb_bus_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_m0_stb,
    input  logic              i_m1_stb,
    input  logic              i_m0_we,
    input  logic              i_m1_we,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic [DATA_W-1:0] i_m0_data,
    input  logic [DATA_W-1:0] i_m1_data,
    input  logic [SEL_W-1:0]  i_m0_sel,
    input  logic [SEL_W-1:0]  i_m1_sel,
    output logic [DATA_W-1:0] o_m0_data,
    output logic [DATA_W-1:0] o_m1_data,
    output logic              o_m0_ack,
    output logic              o_m1_ack,
    output logic              o_m0_err,
    output logic              o_m1_err,
    output logic              o_m0_stall,
    output logic              o_m1_stall,
    output logic              o_s_stb,
    output logic              o_s_we,
    output logic [ADDR_W-1:0] o_s_addr,
    output logic [DATA_W-1:0] o_s_data,
    output logic [SEL_W-1:0]  o_s_sel,
    input  logic [DATA_W-1:0] i_s_data,
    input  logic              i_s_ack,
    input  logic              i_s_stall,
    output logic              o_grant
);

    localparam int CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    arb_state_t        state;
    logic [CNT_W-1:0]  count;
    logic [1:0]        ack_q;
    logic [1:0]        err_q;
    logic [DATA_W-1:0] rdata_q [2];

    logic [1:0]        req_stb;
    logic [1:0]        req_we_in;
    logic [ADDR_W-1:0] req_addr_in [2];
    logic [DATA_W-1:0] req_data_in [2];
    logic [SEL_W-1:0]  req_sel_in  [2];

    logic [1:0]        pend;
    logic [1:0]        clear;
    logic [1:0]        lat_we;
    logic [ADDR_W-1:0] lat_addr [2];
    logic [DATA_W-1:0] lat_data [2];
    logic [SEL_W-1:0]  lat_sel  [2];

    logic              next_g;
    logic              timeout_hit;

    assign req_stb        = {i_m1_stb, i_m0_stb};
    assign req_we_in      = {i_m1_we, i_m0_we};
    assign req_addr_in[0] = i_m0_addr;
    assign req_addr_in[1] = i_m1_addr;
    assign req_data_in[0] = i_m0_data;
    assign req_data_in[1] = i_m1_data;
    assign req_sel_in[0]  = i_m0_sel;
    assign req_sel_in[1]  = i_m1_sel;

    for (genvar g = 0; g < 2; g++) begin : g_req
        wb_req_latch #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .SEL_W  (SEL_W)
        ) u_req (
            .i_clk     (i_clk),
            .i_reset   (i_reset),
            .i_stb     (req_stb[g]),
            .i_we      (req_we_in[g]),
            .i_addr    (req_addr_in[g]),
            .i_data    (req_data_in[g]),
            .i_sel     (req_sel_in[g]),
            .i_ack     (ack_q[g]),
            .i_clear   (clear[g]),
            .o_pending (pend[g]),
            .o_we      (lat_we[g]),
            .o_addr    (lat_addr[g]),
            .o_data    (lat_data[g]),
            .o_sel     (lat_sel[g])
        );
    end

    // On a tie the master that was not granted last wins.
    assign next_g      = (pend == 2'b11) ? ~o_grant : (pend[1] ? M_DBG : M_CPU);
    assign timeout_hit = (TIMEOUT != 0) && (count == CNT_LAST);

    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        clear = 2'b00;
        if (state == S_WAIT && (i_s_ack || timeout_hit)) begin
            clear[o_grant] = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= S_IDLE;
            count      <= '0;
            o_grant    <= M_DBG;
            o_s_stb    <= 1'b0;
            o_s_we     <= 1'b0;
            o_s_addr   <= '1;
            o_s_data   <= '1;
            o_s_sel    <= '0;
            ack_q      <= 2'b00;
            err_q      <= 2'b00;
            rdata_q[0] <= '1;
            rdata_q[1] <= '1;
        end else begin
            ack_q   <= 2'b00;
            err_q   <= 2'b00;
            o_s_stb <= 1'b0;
            case (state)
                S_IDLE: begin
                    if ((|pend) && !i_s_stall) begin
                        o_s_stb  <= 1'b1;
                        o_s_we   <= lat_we[next_g];
                        o_s_addr <= lat_addr[next_g];
                        o_s_data <= lat_data[next_g];
                        o_s_sel  <= lat_sel[next_g];
                        o_grant  <= next_g;
                        count    <= '0;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    count <= count + 1'b1;
                    // Ack takes precedence over a watchdog expiry in the same cycle.
                    if (i_s_ack) begin
                        rdata_q[o_grant] <= i_s_data;
                        ack_q[o_grant]   <= 1'b1;
                        state            <= S_IDLE;
                    end else if (timeout_hit) begin
                        err_q[o_grant] <= 1'b1;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_m0_ack   = ack_q[0];
    assign o_m1_ack   = ack_q[1];
    assign o_m0_err   = err_q[0];
    assign o_m1_err   = err_q[1];
    assign o_m0_data  = rdata_q[0];
    assign o_m1_data  = rdata_q[1];
    assign o_m0_stall = pend[0];
    assign o_m1_stall = pend[1];

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Directed bench for wb_bus_arbiter: behavioural 1-cycle-ack slave, event
// monitor and hand-computed expectations for each scenario.
module tb_wb_bus_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int SEL_W   = 4;
    localparam int TIMEOUT = 8;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_m0_stb, i_m1_stb, i_m0_we, i_m1_we;
    logic [ADDR_W-1:0] i_m0_addr, i_m1_addr;
    logic [DATA_W-1:0] i_m0_data, i_m1_data;
    logic [SEL_W-1:0]  i_m0_sel, i_m1_sel;
    logic [DATA_W-1:0] o_m0_data, o_m1_data;
    logic              o_m0_ack, o_m1_ack, o_m0_err, o_m1_err;
    logic              o_m0_stall, o_m1_stall;
    logic              o_s_stb, o_s_we;
    logic [ADDR_W-1:0] o_s_addr;
    logic [DATA_W-1:0] o_s_data;
    logic [SEL_W-1:0]  o_s_sel;
    logic [DATA_W-1:0] i_s_data;
    logic              i_s_ack, i_s_stall;
    logic              o_grant;

    wb_bus_arbiter #(
        .ADDR_W (ADDR_W), .DATA_W (DATA_W), .SEL_W (SEL_W), .TIMEOUT (TIMEOUT)
    ) dut (
        .i_clk (i_clk), .i_reset (i_reset),
        .i_m0_stb (i_m0_stb), .i_m1_stb (i_m1_stb),
        .i_m0_we (i_m0_we), .i_m1_we (i_m1_we),
        .i_m0_addr (i_m0_addr), .i_m1_addr (i_m1_addr),
        .i_m0_data (i_m0_data), .i_m1_data (i_m1_data),
        .i_m0_sel (i_m0_sel), .i_m1_sel (i_m1_sel),
        .o_m0_data (o_m0_data), .o_m1_data (o_m1_data),
        .o_m0_ack (o_m0_ack), .o_m1_ack (o_m1_ack),
        .o_m0_err (o_m0_err), .o_m1_err (o_m1_err),
        .o_m0_stall (o_m0_stall), .o_m1_stall (o_m1_stall),
        .o_s_stb (o_s_stb), .o_s_we (o_s_we),
        .o_s_addr (o_s_addr), .o_s_data (o_s_data), .o_s_sel (o_s_sel),
        .i_s_data (i_s_data), .i_s_ack (i_s_ack), .i_s_stall (i_s_stall),
        .o_grant (o_grant)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Slave model and event monitor, sampled on the falling edge.
    logic        ack_en    = 1'b1;
    logic        use_fixed = 1'b0;
    logic [31:0] fixed_rdata = 32'h0;
    logic        stb_d = 1'b0;
    logic [31:0] addr_d = 32'h0;
    int stb_cnt, m0_ack_cnt, m1_ack_cnt, m0_err_cnt, m1_err_cnt;
    int stb_cyc, err_cyc, m0_acks_at_m1_ack, n_log;
    int grant_log [16];

    task automatic clear_mon();
        stb_cnt = 0; m0_ack_cnt = 0; m1_ack_cnt = 0; m0_err_cnt = 0; m1_err_cnt = 0;
        stb_cyc = 0; err_cyc = 0; m0_acks_at_m1_ack = -1; n_log = 0;
    endtask

    initial begin
        i_s_ack  = 1'b0;
        i_s_data = '0;
        clear_mon();
        forever begin
            @(negedge i_clk);
            i_s_ack  = ack_en && stb_d;
            i_s_data = use_fixed ? fixed_rdata : {16'hC0DE, addr_d[15:0]};
            stb_d    = o_s_stb;
            if (o_s_stb) begin
                addr_d  = o_s_addr;
                stb_cnt++;
                stb_cyc = cyc;
                if (n_log < 16) begin
                    grant_log[n_log] = int'(o_grant);
                    n_log++;
                end
            end
            if (o_m0_ack) m0_ack_cnt++;
            if (o_m1_ack) begin
                m1_ack_cnt++;
                m0_acks_at_m1_ack = m0_ack_cnt;
            end
            if (o_m0_err) begin
                m0_err_cnt++;
                err_cyc = cyc;
            end
            if (o_m1_err) m1_err_cnt++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge i_clk);
            #1;
        end
    endtask

    task automatic idle_inputs();
        i_m0_stb = 0; i_m1_stb = 0; i_m0_we = 0; i_m1_we = 0;
        i_m0_addr = '0; i_m1_addr = '0; i_m0_data = '0; i_m1_data = '0;
        i_m0_sel = 4'hF; i_m1_sel = 4'hF; i_s_stall = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_reset = 1'b1;
        tick(2);
        i_reset = 1'b0;
        tick(1);
        clear_mon();
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_m0_ack"},   o_m0_ack,   1'b0);
        check({p, "_m1_ack"},   o_m1_ack,   1'b0);
        check({p, "_m0_err"},   o_m0_err,   1'b0);
        check({p, "_m1_err"},   o_m1_err,   1'b0);
        check({p, "_m0_stall"}, o_m0_stall, 1'b0);
        check({p, "_m1_stall"}, o_m1_stall, 1'b0);
        check({p, "_s_stb"},    o_s_stb,    1'b0);
        check({p, "_s_we"},     o_s_we,     1'b0);
        check({p, "_s_addr"},   o_s_addr,   32'hFFFF_FFFF);
        check({p, "_s_data"},   o_s_data,   32'hFFFF_FFFF);
        check({p, "_s_sel"},    o_s_sel,    4'h0);
        check({p, "_m0_data"},  o_m0_data,  32'hFFFF_FFFF);
        check({p, "_m1_data"},  o_m1_data,  32'hFFFF_FFFF);
        check({p, "_grant"},    o_grant,    1'b1);
    endtask

    initial begin
        logic seen;
        idle_inputs();
        i_reset = 1'b1;
        tick(1);
        check_reset_vals("rst");
        i_reset = 1'b0;
        tick(1);
        clear_mon();

        // 1: single master-0 read, acceptance -> stb +1 edge -> ack +3 edges
        use_fixed = 1'b1; fixed_rdata = 32'hDEAD_BEEF;
        i_m0_stb = 1; i_m0_we = 0; i_m0_addr = 32'h10;
        tick();
        i_m0_stb = 0;
        check("t1_stall_set", o_m0_stall, 1'b1);
        check("t1_no_stb_yet", o_s_stb, 1'b0);
        tick();
        check("t1_s_stb", o_s_stb, 1'b1);
        check("t1_s_addr", o_s_addr, 32'h10);
        check("t1_s_we", o_s_we, 1'b0);
        check("t1_grant", o_grant, 1'b0);
        tick();
        check("t1_no_early_ack", o_m0_ack, 1'b0);
        tick();
        check("t1_ack", o_m0_ack, 1'b1);
        check("t1_rdata", o_m0_data, 32'hDEAD_BEEF);
        check("t1_stall_clr", o_m0_stall, 1'b0);
        tick();
        check("t1_ack_pulse", o_m0_ack, 1'b0);
        check("t1_rdata_hold", o_m0_data, 32'hDEAD_BEEF);
        check("t1_one_stb", stb_cnt, 1);
        use_fixed = 1'b0;

        // 2: simultaneous strobes after reset, m0 first, acks routed per master
        do_reset();
        i_m0_stb = 1; i_m0_we = 1; i_m0_addr = 32'h4; i_m0_data = 32'h1111_1111; i_m0_sel = 4'h3;
        i_m1_stb = 1; i_m1_we = 0; i_m1_addr = 32'h8;
        tick();
        i_m0_stb = 0; i_m1_stb = 0;
        tick();
        check("t2_s_stb0", o_s_stb, 1'b1);
        check("t2_grant0", o_grant, 1'b0);
        check("t2_addr0", o_s_addr, 32'h4);
        check("t2_we0", o_s_we, 1'b1);
        check("t2_wdata0", o_s_data, 32'h1111_1111);
        check("t2_sel0", o_s_sel, 4'h3);
        tick(2);
        check("t2_m0_ack", o_m0_ack, 1'b1);
        check("t2_m1_no_ack", o_m1_ack, 1'b0);
        check("t2_m0_data", o_m0_data, 32'hC0DE_0004);
        check("t2_m1_stall", o_m1_stall, 1'b1);
        tick();
        check("t2_s_stb1", o_s_stb, 1'b1);
        check("t2_grant1", o_grant, 1'b1);
        check("t2_addr1", o_s_addr, 32'h8);
        check("t2_we1", o_s_we, 1'b0);
        tick(2);
        check("t2_m1_ack", o_m1_ack, 1'b1);
        check("t2_m0_no_ack", o_m0_ack, 1'b0);
        check("t2_m1_data", o_m1_data, 32'hC0DE_0008);
        check("t2_m0_data_hold", o_m0_data, 32'hC0DE_0004);

        // 3: m0 re-requests continuously; slave stalls until both pending
        do_reset();
        i_m0_addr = 32'h100; i_m1_addr = 32'h200;
        for (int c = 0; c < 60 && n_log < 3; c++) begin
            i_m0_stb  = !o_m0_stall;
            i_m1_stb  = (c == 0);
            i_s_stall = (m1_ack_cnt == 0) && !(o_m0_stall && o_m1_stall);
            tick();
        end
        i_m0_stb = 0; i_m1_stb = 0; i_s_stall = 0;
        tick(4);
        check("t3_n_grants", n_log, 3);
        check("t3_grant_a", grant_log[0], 0);
        check("t3_grant_b", grant_log[1], 1);
        check("t3_grant_c", grant_log[2], 0);
        check("t3_m1_waited_one", m0_acks_at_m1_ack, 1);
        check("t3_m0_acks", m0_ack_cnt, 2);
        check("t3_m1_acks", m1_ack_cnt, 1);

        // 4: stb held through the ack cycle must not be re-accepted
        do_reset();
        i_m0_stb = 1; i_m0_addr = 32'h40;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            seen = o_m0_ack;
        end
        check("t4_ack_seen", seen, 1'b1);
        tick();
        i_m0_stb = 0;
        tick(6);
        check("t4_one_stb", stb_cnt, 1);
        check("t4_one_ack", m0_ack_cnt, 1);
        check("t4_stall_clr", o_m0_stall, 1'b0);

        // 5: watchdog with a silent slave, then a normal transaction
        do_reset();
        ack_en = 1'b0;
        i_m0_stb = 1; i_m0_addr = 32'h80;
        tick();
        i_m0_stb = 0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            seen = o_m0_err || o_m0_ack;
            if (c == 3) check("t5_stall_wait", o_m0_stall, 1'b1);
        end
        check("t5_err", o_m0_err, 1'b1);
        check("t5_err_delay", err_cyc - stb_cyc, 8);
        check("t5_no_ack", m0_ack_cnt, 0);
        check("t5_stall_clr", o_m0_stall, 1'b0);
        tick();
        check("t5_err_pulse", o_m0_err, 1'b0);
        ack_en = 1'b1;
        i_m0_stb = 1; i_m0_addr = 32'h84;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            i_m0_stb = 0;
            seen = o_m0_ack;
        end
        check("t5_retry_ack", seen, 1'b1);
        check("t5_retry_data", o_m0_data, 32'hC0DE_0084);
        check("t5_err_count", m0_err_cnt, 1);

        // 6: slave stall holds off the grant, then reset lands mid-WAIT
        do_reset();
        i_s_stall = 1;
        i_m1_stb = 1; i_m1_addr = 32'h300;
        tick();
        i_m1_stb = 0;
        tick(5);
        check("t6_no_stb_stalled", stb_cnt, 0);
        check("t6_m1_pending", o_m1_stall, 1'b1);
        i_s_stall = 0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            tick();
            seen = (stb_cnt > 0);
        end
        check("t6_stb_issued", seen, 1'b1);
        i_reset = 1'b1;
        #1;
        check_reset_vals("t6_rst");
        i_reset = 1'b0;
        tick(5);
        check("t6_stray_ack_ignored", m1_ack_cnt, 0);
        check("t6_no_err", m1_err_cnt, 0);
        check("t6_no_reissue", stb_cnt, 1);
        check("t6_stall_clr", o_m1_stall, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
